// File: rtl/ieee80211_descrambler.sv
`default_nettype none
// ==========================================================================
// ieee80211_descrambler : 802.11 RX descrambler (x^7+x^4+1), reseeded from
// SERVICE bits 0-6 of every frame. Macro IEEE80211_DESCRAMBLER_SEED_OUT_EN
// adds seed_out/seed_valid.                          Revision: 1.0
// ==========================================================================
module ieee80211_descrambler #(
  parameter int WIDTH = 24
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [3:0]       s_axis_tuser,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [3:0]       m_axis_tuser
`ifdef IEEE80211_DESCRAMBLER_SEED_OUT_EN
  ,
  output logic [6:0]       seed_out,
  output logic             seed_valid
`endif
);

  generate
    if (WIDTH < 7) begin : g_width_chk
      $error("ieee80211_descrambler: WIDTH must be >= 7");
    end
  endgenerate

  typedef enum logic [0:0] {
    SEED = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [6:0]       st_q;
  logic [6:0]       st_d;
  logic [6:0]       seed_d;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             last_q;
  logic [3:0]       user_q;
  logic             in_xfer;

  // Earliest received bit is the oldest scrambler state bit.
  assign seed_d = {s_axis_tdata[0], s_axis_tdata[1], s_axis_tdata[2], s_axis_tdata[3],
                   s_axis_tdata[4], s_axis_tdata[5], s_axis_tdata[6]};

  assign s_axis_tready = !valid_q || m_axis_tready;
  assign in_xfer       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    logic [6:0] s;
    logic       key;
    s      = (state_q == SEED) ? seed_d : st_q;
    key    = 1'b0;
    data_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!((state_q == SEED) && (i < 7))) begin
        key       = s[6] ^ s[3];
        data_d[i] = s_axis_tdata[i] ^ key;
        s         = {s[5:0], key};
      end
    end
    st_d = s;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= SEED;
      st_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      last_q  <= s_axis_tlast;
      user_q  <= s_axis_tuser;
      st_q    <= st_d;
      state_q <= s_axis_tlast ? SEED : RUN;
    end else if (m_axis_tready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tuser  = user_q;

`ifdef IEEE80211_DESCRAMBLER_SEED_OUT_EN
  logic [6:0] seed_q;
  logic       seed_valid_q;

  // The pulse coincides with the seed beat first appearing on the output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
    end else begin
      seed_valid_q <= in_xfer && (state_q == SEED);
      if (in_xfer && (state_q == SEED)) begin
        seed_q <= seed_d;
      end
    end
  end

  assign seed_out   = seed_q;
  assign seed_valid = seed_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ieee80211_descrambler.sv
`default_nettype none
// Bench for ieee80211_descrambler: a TX-scrambler reference model feeds a
// scoreboard of original payloads, which is checked against every output transfer.
module tb_ieee80211_descrambler;
  localparam int W    = 24;
  localparam int MAXB = 16;
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_54M = 4'b0011;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [3:0]   user;
  } beat_t;

  logic         aclk     = 1'b0;
  logic         areset   = 1'b1;
  logic [W-1:0] s_tdata  = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast  = 1'b0;
  logic [3:0]   s_tuser  = '0;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;
  logic [3:0]   m_tuser;
`ifdef IEEE80211_DESCRAMBLER_SEED_OUT_EN
  logic [6:0]   seed_out;
  logic         seed_valid;
  int           seed_pulses = 0;
`endif

  logic [W-1:0] s_plain = '0;
  logic [W-1:0] payload [MAXB];
  logic [W-1:0] scr     [MAXB];
  beat_t        exp_q [$];
  int           ready_mode = 0;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 aclk = ~aclk;

  ieee80211_descrambler #(.WIDTH(W)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser)
`ifdef IEEE80211_DESCRAMBLER_SEED_OUT_EN
    ,
    .seed_out      (seed_out),
    .seed_valid    (seed_valid)
`endif
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Keystream as the recurrence k[n] = k[n-7] ^ k[n-4]; ks[0..6] is the seed, oldest first.
  task automatic tx_scramble(input logic [6:0] seed, input int nb);
    logic ks [0:MAXB*W+6];
    for (int j = 0; j < 7; j++) ks[j] = seed[6-j];
    for (int n = 7; n < nb*W + 7; n++) ks[n] = ks[n-7] ^ ks[n-4];
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < W; i++)
        scr[b][i] = payload[b][i] ^ ks[b*W + i + 7];
  endtask

  task automatic gen_payload(input int nb, input bit zero);
    for (int b = 0; b < nb; b++) payload[b] = zero ? '0 : W'($urandom);
    payload[0][6:0] = '0;
  endtask

  task automatic wait_accept();
    bit ok;
    int t;
    ok = 1'b0;
    t  = 0;
    while (!ok) begin
      @(negedge aclk);
      ok = s_tready;
      @(posedge aclk);
      #1;
      t++;
      if (!ok && t > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: tready low for %0d cycles, required a transfer", t);
        ok = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [6:0] seed, input int nb, input int nsend,
                            input logic [3:0] user, input int gap);
    tx_scramble(seed, nb);
    for (int b = 0; b < nsend; b++) begin
      s_tdata  = scr[b];
      s_plain  = payload[b];
      s_tlast  = (b == nb - 1);
      s_tuser  = user;
      s_tvalid = 1'b1;
      wait_accept();
      if (gap > 0 && b != nsend - 1) begin
        s_tvalid = 1'b0;
        s_tdata  = W'($urandom);
        repeat (gap) @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t        = 0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge aclk);
      #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats pending, required 0", name, exp_q.size());
    end
  endtask

  // Downstream ready: all-ones, or drawn from the 1,0,0,1 pattern at random positions.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = (ready_mode == 0) ? 1'b1 : pat[$urandom_range(0, 3)];
    end
  end

  // Scoreboard: pop on output transfer, push on input transfer, hold-check while stalled.
  initial begin
    beat_t e;
    beat_t stall_beat;
    bit    stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_tvalid", W'(m_tvalid), W'(1'b1));
          check("stall_tdata", m_tdata, stall_beat.data);
          check("stall_tlast", W'(m_tlast), W'(stall_beat.last));
          check("stall_tuser", W'(m_tuser), W'(stall_beat.user));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h, required no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("tdata", m_tdata, e.data);
            check("tlast", W'(m_tlast), W'(e.last));
            check("tuser", W'(m_tuser), W'(e.user));
          end
        end
        stall_prev = m_tvalid && !m_tready;
        if (stall_prev) begin
          stall_beat.data = m_tdata;
          stall_beat.last = m_tlast;
          stall_beat.user = m_tuser;
        end
        if (s_tvalid && s_tready) begin
          e.data = s_plain;
          e.last = s_tlast;
          e.user = s_tuser;
          exp_q.push_back(e);
        end
`ifdef IEEE80211_DESCRAMBLER_SEED_OUT_EN
        if (seed_valid) seed_pulses++;
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rst_tvalid", W'(m_tvalid), '0);
    check("rst_tdata", m_tdata, '0);
    check("rst_tlast", W'(m_tlast), '0);
    check("rst_tuser", W'(m_tuser), '0);
    check("rst_tready", W'(s_tready), W'(1'b1));
    @(posedge aclk);
    #1;

    // Model pinned to the known all-ones keystream.
    gen_payload(3, 1'b1);
    tx_scramble(7'h7F, 3);
    check("model_beat0", scr[0], 24'h934F70);
    check("model_beat1", scr[1], 24'h746440);

    // All-zero frame, with idle gaps mid-frame.
    send_frame(7'h7F, 3, 3, RATE_6M, 2);
    drain("zero_frame");
`ifdef IEEE80211_DESCRAMBLER_SEED_OUT_EN
    check("seed_out", W'(seed_out), W'(7'b0000111));
    check("seed_pulses", W'(seed_pulses), W'(1));
`endif

    // Random 10-beat payload, then the same stimulus with a stalling sink.
    gen_payload(10, 1'b0);
    send_frame(7'h5D, 10, 10, RATE_9M, 0);
    drain("rand_frame");
    ready_mode = 1;
    send_frame(7'h5D, 10, 10, RATE_9M, 0);
    drain("stalled_frame");
    ready_mode = 0;
    @(posedge aclk);
    #1;

    // Back-to-back frames with different seeds.
    gen_payload(3, 1'b0);
    send_frame(7'h7F, 3, 3, RATE_12M, 0);
    gen_payload(4, 1'b0);
    send_frame(7'h2A, 4, 4, RATE_54M, 0);
    drain("b2b_frames");

    // Reset after beat 1 of a 4-beat frame, then a fresh frame.
    gen_payload(4, 1'b0);
    send_frame(7'h19, 4, 2, RATE_12M, 0);
    s_tvalid = 1'b0;
    areset   = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("post_reset_tvalid", W'(m_tvalid), '0);
    @(posedge aclk);
    #1;
    gen_payload(3, 1'b0);
    send_frame(7'h6E, 3, 3, RATE_54M, 0);
    drain("after_reset");

    // Single-beat frame followed directly by a 2-beat frame.
    gen_payload(1, 1'b0);
    send_frame(7'h33, 1, 1, RATE_6M, 0);
    gen_payload(2, 1'b0);
    send_frame(7'h4C, 2, 2, RATE_9M, 0);
    drain("single_beat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
